// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready request side and
// valid/ready result side with status flags.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] sum_hi;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, operation, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, sum_hi, cout, zero, neg, ovf, illegal
    );

    modport slave (
        input  in_valid, operation, a, b, cin, out_ready,
        output in_ready, out_valid, sum, sum_hi, cout, zero, neg, ovf, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready operand intake and a one-entry result register.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 1101.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave io
);
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_NOTA  = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_PSB2  = 4'b1000;
    localparam logic [3:0] OP_ADC   = 4'b1001;
    localparam logic [3:0] OP_SBB   = 4'b1010;
    localparam logic [3:0] OP_SHL   = 4'b1011;
    localparam logic [3:0] OP_SHR   = 4'b1100;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'b1101;

    typedef enum logic {S_IDLE, S_MUL} state_e;
`else
    typedef enum logic {S_IDLE} state_e;
`endif

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   sum_hi_q, sum_hi_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    logic             accept, drain;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout, r_ovf, r_ill;

    assign io.in_ready = (state_q == S_IDLE) && (!out_valid_q || io.out_ready);
    assign accept      = io.in_valid && io.in_ready;
    assign drain       = out_valid_q && io.out_ready;

    // Single-cycle datapath; arithmetic is one bit wider so the top bit is carry/borrow.
    always_comb begin
        ext    = '0;
        r_sum  = '0;
        r_cout = 1'b0;
        r_ovf  = 1'b0;
        r_ill  = 1'b0;
        case (io.operation)
            OP_NOP: r_sum = '0;
            OP_ADD, OP_ADC: begin
                ext    = {1'b0, io.a} + {1'b0, io.b}
                       + {{WIDTH{1'b0}}, io.cin & (io.operation == OP_ADC)};
                r_sum  = ext[WIDTH-1:0];
                r_cout = ext[WIDTH];
                r_ovf  = (io.a[WIDTH-1] == io.b[WIDTH-1]) && (r_sum[WIDTH-1] != io.a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                ext    = {1'b0, io.a} - {1'b0, io.b}
                       - {{WIDTH{1'b0}}, io.cin & (io.operation == OP_SBB)};
                r_sum  = ext[WIDTH-1:0];
                r_cout = ext[WIDTH];
                r_ovf  = (io.a[WIDTH-1] != io.b[WIDTH-1]) && (r_sum[WIDTH-1] != io.a[WIDTH-1]);
            end
            OP_OR:           r_sum = io.a | io.b;
            OP_AND:          r_sum = io.a & io.b;
            OP_XOR:          r_sum = io.a ^ io.b;
            OP_NOTA:         r_sum = ~io.a;
            OP_PASSB, OP_PSB2: r_sum = io.b;
            OP_SHL: begin
                r_sum  = {io.a[WIDTH-2:0], 1'b0};
                r_cout = io.a[WIDTH-1];
            end
            OP_SHR: begin
                r_sum  = {1'b0, io.a[WIDTH-1:1]};
                r_cout = io.a[0];
            end
            default: r_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        if (drain) out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
        sum_hi_d = sum_hi_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        prod     = acc_q + (mplier_q[0] ? mcand_q : '0);
        // Output register is empty throughout MUL, so the final step can load it directly.
        if (state_q == S_MUL) begin
            acc_d    = prod;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                sum_d       = prod[WIDTH-1:0];
                sum_hi_d    = prod[2*WIDTH-1:WIDTH];
                cout_d      = |prod[2*WIDTH-1:WIDTH];
                zero_d      = (prod == '0);
                neg_d       = prod[WIDTH-1];
                ovf_d       = 1'b0;
                illegal_d   = 1'b0;
            end
        end else if (accept && io.operation == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, io.a};
            mplier_d = io.b;
        end else
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            sum_d       = r_sum;
            cout_d      = r_cout;
            zero_d      = !r_ill && (r_sum == '0);
            neg_d       = r_sum[WIDTH-1];
            ovf_d       = r_ovf;
            illegal_d   = r_ill;
`ifdef ALU_MUL_EN
            sum_hi_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
            sum_hi_q    <= '0;
            mplier_q    <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
`ifdef ALU_MUL_EN
            sum_hi_q    <= sum_hi_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.zero      = zero_q;
    assign io.neg       = neg_q;
    assign io.ovf       = ovf_q;
    assign io.illegal   = illegal_q;
`ifdef ALU_MUL_EN
    assign io.sum_hi    = sum_hi_q;
`else
    assign io.sum_hi    = '0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed vectors, a queue-based result model checked
// every cycle, and literal expectations for the documented corner cases.
module tb_alu_seq;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    alu_seq_if #(.WIDTH(W)) io ();

    alu_seq #(.WIDTH(W), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         due;
        logic [7:0] s;
        logic [7:0] hi;
        logic       c, z, n, v, il;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [20:0] pk(input logic [7:0] s, input logic [7:0] hi,
                                       input logic c, z, n, v, il);
        return {s, hi, c, z, n, v, il};
    endfunction

    function automatic logic [20:0] outs();
        return {io.sum, io.sum_hi, io.cout, io.zero, io.neg, io.ovf, io.illegal};
    endfunction

    function automatic bit is_mul(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return op == 4'd13;
`else
        return 1'b0;
`endif
    endfunction

    // Expected result from plain integer arithmetic on the opcode table.
    function automatic exp_t model_res(input logic [3:0] op, input logic [7:0] a, b, input logic c);
        exp_t e;
        int ua, ub, sa, sr, r, ci;
        logic [7:0] t;
        bit ill;
        e = '{default: 0};
        ua = a; ub = b; sa = $signed(a); ci = c;
        r = 0; ill = 0;
        case (op)
            4'd0: r = 0;
            4'd1, 4'd9: begin
                if (op == 4'd1) ci = 0;
                r = ua + ub + ci;
                sr = sa + int'($signed(b)) + ci;
                e.c = r > 255;
                e.v = sr > 127 || sr < -128;
            end
            4'd2, 4'd10: begin
                if (op == 4'd2) ci = 0;
                r = ua - ub - ci;
                sr = sa - int'($signed(b)) - ci;
                e.c = ua < ub + ci;
                e.v = sr > 127 || sr < -128;
            end
            4'd3: r = a | b;
            4'd4: r = a & b;
            4'd5: r = a ^ b;
            4'd6: begin t = ~a; r = t; end
            4'd7, 4'd8: r = ub;
            4'd11: begin r = ua * 2; e.c = ua >= 128; end
            4'd12: begin r = ua / 2; e.c = (ua % 2) == 1; end
            4'd13: if (is_mul(op)) r = ua * ub; else ill = 1;
            default: ill = 1;
        endcase
        if (ill) begin
            e.il = 1;
        end else if (is_mul(op)) begin
            e.s = r % 256;
            e.hi = r / 256;
            e.c = e.hi != 0;
            e.z = r == 0;
            e.n = e.s[7];
        end else begin
            e.s = r & 255;
            e.z = e.s == 0;
            e.n = e.s[7];
        end
        return e;
    endfunction

    // Model update on each rising edge: drain, then accept.
    initial begin
        bit mov, infl, rdy;
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
            end else begin
                mov = 0; infl = 0;
                if (q.size() > 0) begin
                    mov  = cyc >= q[0].due;
                    infl = q[0].due > cyc;
                end
                rdy = !infl && (!mov || io.out_ready);
                if (mov && io.out_ready) void'(q.pop_front());
                if (io.in_valid && rdy) begin
                    e = model_res(io.operation, io.a, io.b, io.cin);
                    e.due = cyc + 1 + (is_mul(io.operation) ? W : 0);
                    q.push_back(e);
                end
            end
            cyc++;
        end
    end

    // Per-cycle compare against the model, sampled mid-low-phase.
    initial begin
        bit mov, infl;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                mov = 0; infl = 0;
                if (q.size() > 0) begin
                    mov  = cyc >= q[0].due;
                    infl = q[0].due > cyc;
                end
                chk("out_valid", io.out_valid, mov);
                chk("in_ready", io.in_ready, !infl && (!mov || io.out_ready));
                if (mov && io.out_valid)
                    chk("model_result", outs(),
                        pk(q[0].s, q[0].hi, q[0].c, q[0].z, q[0].n, q[0].v, q[0].il));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // Starts and ends on a falling edge; returns the model cycle count at the accept edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, b, input logic c,
                         output int acc_cyc);
        bit got;
        int n;
        io.operation = op; io.a = a; io.b = b; io.cin = c; io.in_valid = 1'b1;
        got = 0; n = 0;
        while (!got && n < 40) begin
            #1 got = io.in_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        io.in_valid = 1'b0;
        io.a = ~a; io.b = ~b; io.cin = ~c; io.operation = 4'd1;
        chk("accept", got, 1);
    endtask

    task automatic wait_result(output logic [20:0] r, output int seen);
        int n;
        n = 0;
        #2;
        while (!io.out_valid && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("result_arrives", io.out_valid, 1);
        r = outs();
        seen = cyc;
    endtask

    initial begin
        logic [20:0] r;
        int ac, seen;
        logic [7:0] va[3];
        logic [7:0] vb[3];
        logic       vc[3];
        va = '{8'h7F, 8'h55, 8'h00};
        vb = '{8'h01, 8'hAA, 8'hFF};
        vc = '{1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        io.in_valid = 1'b0; io.operation = 4'd0; io.a = '0; io.b = '0; io.cin = 1'b0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset_out_valid", io.out_valid, 0);
        chk("reset_outputs", outs(), 0);
        chk("reset_in_ready", io.in_ready, 1);

        issue(4'd1, 8'hFF, 8'h01, 1'b0, ac); wait_result(r, seen);
        chk("add_latency", seen - ac, 0);
        chk("add_ff_01", r, pk(8'h00, 8'h00, 1, 1, 0, 0, 0));

        issue(4'd2, 8'h80, 8'h01, 1'b0, ac); wait_result(r, seen);
        chk("sub_80_01", r, pk(8'h7F, 8'h00, 0, 0, 0, 1, 0));

        issue(4'd10, 8'h00, 8'h00, 1'b1, ac); wait_result(r, seen);
        chk("sbb_0_0_1", r, pk(8'hFF, 8'h00, 1, 0, 1, 0, 0));

        issue(4'd13, 8'd200, 8'd3, 1'b0, ac); wait_result(r, seen);
`ifdef ALU_MUL_EN
        chk("mul_latency", seen - ac, W);
        chk("mul_200_3", r, pk(8'h58, 8'h02, 1, 0, 0, 0, 0));
`else
        chk("mul_off_latency", seen - ac, 0);
        chk("mul_off_illegal", r, pk(8'h00, 8'h00, 0, 0, 0, 0, 1));
`endif

        issue(4'd14, 8'h12, 8'h34, 1'b0, ac); wait_result(r, seen);
        chk("op_1110_illegal", r, pk(8'h00, 8'h00, 0, 0, 0, 0, 1));

        issue(4'd11, 8'h81, 8'h00, 1'b0, ac); wait_result(r, seen);
        chk("shl_81", r, pk(8'h02, 8'h00, 1, 0, 0, 0, 0));

        issue(4'd12, 8'h01, 8'h00, 1'b0, ac); wait_result(r, seen);
        chk("shr_01", r, pk(8'h00, 8'h00, 1, 1, 0, 0, 0));

        // Backpressure: result held, second request waits, then drain+accept together.
        @(negedge clk);
        io.out_ready = 1'b0;
        issue(4'd4, 8'hF0, 8'h3C, 1'b0, ac); wait_result(r, seen);
        chk("and_f0_3c", r, pk(8'h30, 8'h00, 0, 0, 0, 0, 0));
        @(negedge clk);
        io.operation = 4'd3; io.a = 8'h0F; io.b = 8'h30; io.cin = 1'b0; io.in_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("bp_in_ready_low", io.in_ready, 0);
            chk("bp_result_held", outs(), pk(8'h30, 8'h00, 0, 0, 0, 0, 0));
            @(negedge clk);
        end
        io.out_ready = 1'b1;
        #1 chk("bp_drain_accept_ready", io.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        io.in_valid = 1'b0;
        #2;
        chk("b2b_out_valid", io.out_valid, 1);
        chk("b2b_or_result", outs(), pk(8'h3F, 8'h00, 0, 0, 0, 0, 0));

        // Reset with work in flight.
        @(negedge clk);
`ifdef ALU_MUL_EN
        issue(4'd13, 8'd200, 8'd3, 1'b0, ac);
        repeat (2) @(negedge clk);
`else
        io.out_ready = 1'b0;
        issue(4'd13, 8'd200, 8'd3, 1'b0, ac);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        io.out_ready = 1'b1;
        #2;
        chk("midrst_out_valid", io.out_valid, 0);
        chk("midrst_outputs", outs(), 0);
        chk("midrst_in_ready", io.in_ready, 1);
        repeat (12) @(negedge clk);
        #2 chk("midrst_no_late_result", io.out_valid, 0);

        // Opcode sweep, checked by the model.
        @(negedge clk);
        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 3; k++) begin
                issue(4'(op), va[k], vb[k], vc[k], ac);
                wait_result(r, seen);
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
